// File: rtl/mmio_uart_tx_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mmio_uart_tx_pkg
//  Purpose  : Shared definitions for the memory-mapped UART transmitter:
//             register offsets, STATUS bit positions, TX FSM state encoding
//             and the STATUS word packing helper.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package mmio_uart_tx_pkg;

  // Byte offsets of the register map (bits [1:0] are never decoded)
  localparam logic [3:0] UART_TXDATA = 4'h0;
  localparam logic [3:0] UART_STATUS = 4'h4;

  // STATUS bit indices
  localparam int STAT_BUSY  = 0;
  localparam int STAT_FULL  = 1;
  localparam int STAT_EMPTY = 2;
  localparam int STAT_OVF   = 3;

  // Transmitter state encoding
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_t;

  // STATUS = {16'b0, count[7:0], 4'b0, ovf, empty, full, busy}
  function automatic logic [31:0] pack_status(input logic [7:0] count,
                                              input logic       ovf,
                                              input logic       empty,
                                              input logic       full,
                                              input logic       busy);
    return {16'b0, count, 4'b0, ovf, empty, full, busy};
  endfunction

endpackage
`default_nettype wire

// File: rtl/mmio_uart_tx_if.sv
`default_nettype none
// ============================================================================
//  Module   : mmio_uart_tx_if
//  Purpose  : CPU data-memory store/load bus into the UART transmitter.
//  Ports    : mmio_sel   - access targets the block this cycle
//             mmio_we    - 1 = store, 0 = load
//             mmio_addr  - byte offset within the block
//             mmio_wdata - store data
//             mmio_rdata - load data, combinational
//  Revision : 1.0 - initial release
// ============================================================================
interface mmio_uart_tx_if #(
  parameter int ADDR_W = 4
);
  logic              mmio_sel;
  logic              mmio_we;
  logic [ADDR_W-1:0] mmio_addr;
  logic [31:0]       mmio_wdata;
  logic [31:0]       mmio_rdata;

  modport master (output mmio_sel, mmio_we, mmio_addr, mmio_wdata, input mmio_rdata);
  modport slave  (input mmio_sel, mmio_we, mmio_addr, mmio_wdata, output mmio_rdata);
endinterface
`default_nettype wire

// File: rtl/mmio_uart_tx_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : sync_fifo
//  Purpose  : Single-clock first-word-fall-through FIFO. A push on a full
//             FIFO is accepted when a pop happens in the same cycle.
//  Ports    : clk, rst_n     - clock, async active-low reset
//             i_push/i_push_data, i_pop/o_pop_data - write / read sides
//             o_full, o_empty, o_count - occupancy flags and level
//  Revision : 1.0 - initial release
// ============================================================================
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  wire logic                     clk,
  input  wire logic                     rst_n,
  input  wire logic                     i_push,
  input  wire logic [WIDTH-1:0]         i_push_data,
  input  wire logic                     i_pop,
  output logic      [WIDTH-1:0]         o_pop_data,
  output logic                          o_full,
  output logic                          o_empty,
  output logic      [$clog2(DEPTH):0]   o_count
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full     = (r_count == (PTR_W+1)'(DEPTH));
  assign o_empty    = (r_count == '0);
  assign o_count    = r_count;
  assign o_pop_data = r_mem[r_rd_ptr];

  assign w_do_pop  = i_pop & ~o_empty;
  // A pop frees the slot being written, so full only blocks a lone push
  assign w_do_push = i_push & (~o_full | w_do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; occupancy is tracked by the pointers
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
  end

endmodule
`default_nettype wire

// File: rtl/mmio_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module   : mmio_uart_tx
//  Purpose  : Memory-mapped 8N1 UART transmitter. Stores to TXDATA queue a
//             byte in the TX FIFO; the FSM serialises bytes LSB first.
//  Ports    : sys_clk   - system clock
//             sys_rst_n - async active-low reset
//             bus       - MMIO slave port (sel/we/addr/wdata/rdata)
//             uart_tx   - serial line, idle high
//  Revision : 1.0 - initial release
// ============================================================================
module mmio_uart_tx
  import mmio_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 16,
  parameter int ADDR_W       = 4
) (
  input  wire logic          sys_clk,
  input  wire logic          sys_rst_n,
  mmio_uart_tx_if.slave      bus,
  output logic               uart_tx
);
  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BAUD_W-1:0] c_baud_last = BAUD_W'(CLKS_PER_BIT - 1);

  // ---------------- bus decode ----------------
  logic [ADDR_W-3:0] w_word;
  logic w_hit_txdata, w_hit_status, w_store, w_load;
  logic w_push_req, w_push_ok, w_ovf_clr;
  logic w_full, w_empty, w_pop, w_busy;
  logic [7:0]       w_fifo_data;
  logic [CNT_W-1:0] w_count;
  logic             r_ovf;
  logic             w_unused;

  assign w_word       = bus.mmio_addr[ADDR_W-1:2];
  assign w_hit_txdata = (w_word == (ADDR_W-2)'(UART_TXDATA[3:2]));
  assign w_hit_status = (w_word == (ADDR_W-2)'(UART_STATUS[3:2]));
  assign w_store      = bus.mmio_sel &  bus.mmio_we;
  assign w_load       = bus.mmio_sel & ~bus.mmio_we;
  assign w_push_req   = w_store & w_hit_txdata;
  assign w_push_ok    = w_push_req & (~w_full | w_pop);
  assign w_ovf_clr    = w_store & w_hit_status & bus.mmio_wdata[STAT_OVF];
  assign w_unused     = ^{bus.mmio_addr[1:0], bus.mmio_wdata[31:8]};

  always_comb begin
    bus.mmio_rdata = '0;
    if (w_load && w_hit_status)
      bus.mmio_rdata = pack_status(8'(w_count), r_ovf, w_empty, w_full, w_busy);
  end

  // Sticky overflow; a drop in the same cycle as a clear keeps it set
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)                    r_ovf <= 1'b0;
    else if (w_push_req && !w_push_ok) r_ovf <= 1'b1;
    else if (w_ovf_clr)                r_ovf <= 1'b0;
  end

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk         (sys_clk),
    .rst_n       (sys_rst_n),
    .i_push      (w_push_ok),
    .i_push_data (bus.mmio_wdata[7:0]),
    .i_pop       (w_pop),
    .o_pop_data  (w_fifo_data),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_count     (w_count)
  );

  // ---------------- transmitter ----------------
  tx_state_t         r_state, w_state_nxt;
  logic [BAUD_W-1:0] r_baud,  w_baud_nxt;
  logic [2:0]        r_bit,   w_bit_nxt;
  logic [7:0]        r_shift, w_shift_nxt;
  logic              r_tx,    w_tx_nxt;
  logic              w_baud_last;

  assign w_baud_last = (r_baud == c_baud_last);
  assign w_busy      = (r_state != ST_IDLE);
  assign uart_tx     = r_tx;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state <= ST_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_baud  <= w_baud_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_tx    <= w_tx_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_pop       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_shift_nxt = w_fifo_data;
          w_baud_nxt  = '0;
          w_bit_nxt   = '0;
          w_state_nxt = ST_START;
        end
      end
      ST_START: begin
        if (w_baud_last) begin
          w_baud_nxt  = '0;
          w_state_nxt = ST_DATA;
        end else begin
          w_baud_nxt = r_baud + BAUD_W'(1);
        end
      end
      ST_DATA: begin
        if (w_baud_last) begin
          w_baud_nxt  = '0;
          w_shift_nxt = {1'b0, r_shift[7:1]};
          if (r_bit == 3'd7) w_state_nxt = ST_STOP;
          else               w_bit_nxt   = r_bit + 3'd1;
        end else begin
          w_baud_nxt = r_baud + BAUD_W'(1);
        end
      end
      ST_STOP: begin
        if (w_baud_last) begin
          w_baud_nxt  = '0;
          w_state_nxt = ST_IDLE;
        end else begin
          w_baud_nxt = r_baud + BAUD_W'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    // Line level is registered from the next state so it changes glitch-free
    case (w_state_nxt)
      ST_START: w_tx_nxt = 1'b0;
      ST_DATA:  w_tx_nxt = w_shift_nxt[0];
      default:  w_tx_nxt = 1'b1;
    endcase
  end

endmodule
`default_nettype wire
